// File: rtl/mod_pkg.sv
// Shared types and sizing helpers for the sequential modulo/divide unit.
package mod_pkg;

    typedef enum logic {
        IDLE,
        CALC
    } mod_state_t;

    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mod_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits, and report the resulting quotient bit.
module mod_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH:0]   r,
    input  logic             msb,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   r_next,
    output logic             q
);
    import mod_pkg::*;

    logic [WIDTH+1:0] r_sh;
    logic [WIDTH:0]   diff;

    // r stays below m, so its top bit is always 0.
    // Keeping it in the compare makes the compare cover the full width.
    assign r_sh   = {r, msb};
    assign q      = (r_sh >= {2'b00, m});
    assign diff   = r_sh[WIDTH:0] - {1'b0, m};
    assign r_next = q ? diff : r_sh[WIDTH:0];

endmodule

// File: rtl/mod_n_seq.sv
// Sequential A mod M / A div M with a run-time divisor, one quotient bit per
// clock, fixed latency of WIDTH cycles and a start/busy/done handshake.
module mod_n_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] M,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] OUT,
    output logic [WIDTH-1:0] QUO,
    output logic             err
);
    import mod_pkg::*;

    localparam int unsigned CW = cnt_w(WIDTH);

    mod_state_t      state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo_sr;
    logic [WIDTH:0]   rem_nxt;
    logic             qbit;
    logic             last;

    mod_step #(.WIDTH(WIDTH)) u_step (
        .r      (rem),
        .msb    (dvd[WIDTH-1]),
        .m      (dvs),
        .r_next (rem_nxt),
        .q      (qbit)
    );

    assign last = (cnt == CW'(1));
    assign busy = (state == CALC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start && (M != '0)) state_nxt = CALC;
            CALC: if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            quo_sr <= '0;
            done   <= 1'b0;
            OUT    <= '0;
            QUO    <= '0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (M == '0) begin
                            // Divide-by-zero completes on the accepting edge.
                            OUT  <= A;
                            QUO  <= '1;
                            err  <= 1'b1;
                            done <= 1'b1;
                        end else begin
                            dvd    <= A;
                            dvs    <= M;
                            rem    <= '0;
                            quo_sr <= '0;
                            cnt    <= CW'(WIDTH);
                        end
                    end
                end
                CALC: begin
                    dvd    <= dvd << 1;
                    rem    <= rem_nxt;
                    quo_sr <= {quo_sr[WIDTH-2:0], qbit};
                    cnt    <= cnt - CW'(1);
                    if (last) begin
                        OUT  <= rem_nxt[WIDTH-1:0];
                        QUO  <= {quo_sr[WIDTH-2:0], qbit};
                        err  <= 1'b0;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_n_seq.sv
// Directed and sweep checks of mod_n_seq at WIDTH 8, 4 and 16.
module tb_mod_n_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       start8, busy8, done8, err8;
    logic [7:0] a8, m8, out8, quo8;
    logic       start4, busy4, done4, err4;
    logic [3:0] a4, m4, out4, quo4;
    logic        start16, busy16, done16, err16;
    logic [15:0] a16, m16, out16, quo16;

    mod_n_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .M(m8),
        .busy(busy8), .done(done8), .OUT(out8), .QUO(quo8), .err(err8)
    );
    mod_n_seq #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .M(m4),
        .busy(busy4), .done(done4), .OUT(out4), .QUO(quo4), .err(err4)
    );
    mod_n_seq #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .A(a16), .M(m16),
        .busy(busy16), .done(done16), .OUT(out16), .QUO(quo16), .err(err16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] m, input logic [7:0] eo,
                       input logic [7:0] eq, input logic ee, input int lat, input string tag);
        int k;
        logic busy_bad;
        @(negedge clk);
        a8 = a; m8 = m; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = ~a; m8 = ~m;
        k = 0; busy_bad = 1'b0;
        while (!done8 && k < 20) begin
            if (!busy8) busy_bad = 1'b1;
            @(posedge clk); #1;
            k++;
        end
        chk({tag, ".done"}, done8, 1);
        chk({tag, ".lat"}, k, lat);
        chk({tag, ".busy_run"}, busy_bad, 0);
        chk({tag, ".busy_end"}, busy8, 0);
        chk({tag, ".out"}, out8, eo);
        chk({tag, ".quo"}, quo8, eq);
        chk({tag, ".err"}, err8, ee);
        @(posedge clk); #1;
        chk({tag, ".done_drop"}, done8, 0);
        chk({tag, ".hold"}, out8, eo);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] m);
        int k;
        logic [3:0] eo, eq;
        logic ee;
        if (m == 0) begin eo = a; eq = 4'hF; ee = 1'b1; end
        else begin eo = a % m; eq = a / m; ee = 1'b0; end
        @(negedge clk);
        a4 = a; m4 = m; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        k = 0;
        while (!done4 && k < 10) begin @(posedge clk); #1; k++; end
        chk("w4.lat", k, (m == 0) ? 0 : 4);
        chk("w4.out", out4, eo);
        chk("w4.quo", quo4, eq);
        chk("w4.err", err4, ee);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] m);
        int k;
        logic [15:0] eo, eq;
        logic ee;
        if (m == 0) begin eo = a; eq = 16'hFFFF; ee = 1'b1; end
        else begin eo = a % m; eq = a / m; ee = 1'b0; end
        @(negedge clk);
        a16 = a; m16 = m; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        k = 0;
        while (!done16 && k < 24) begin @(posedge clk); #1; k++; end
        chk("w16.lat", k, (m == 0) ? 0 : 16);
        chk("w16.out", out16, eo);
        chk("w16.quo", quo16, eq);
        chk("w16.err", err16, ee);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int nd;
        int dt[3];
        logic [7:0] dout[3];
        logic [7:0] dquo[3];
        int seen;

        rst_n = 1'b0;
        start8 = 0; a8 = 0; m8 = 0;
        start4 = 0; a4 = 0; m4 = 0;
        start16 = 0; a16 = 0; m16 = 0;
        repeat (3) @(negedge clk);
        chk("rst.busy", busy8, 0);
        chk("rst.done", done8, 0);
        chk("rst.out", out8, 0);
        chk("rst.quo", quo8, 0);
        chk("rst.err", err8, 0);
        rst_n = 1'b1;

        op8(8'd200, 8'd7,   8'd4,  8'd28, 1'b0, 8, "a200m7");
        op8(8'd13,  8'd4,   8'd1,  8'd3,  1'b0, 8, "a13m4");
        op8(8'd5,   8'd9,   8'd5,  8'd0,  1'b0, 8, "a5m9");
        op8(8'd255, 8'd255, 8'd0,  8'd1,  1'b0, 8, "a255m255");
        op8(8'd0,   8'd1,   8'd0,  8'd0,  1'b0, 8, "a0m1");
        op8(8'd77,  8'd0,   8'd77, 8'd255, 1'b1, 0, "m0");
        op8(8'd13,  8'd4,   8'd1,  8'd3,  1'b0, 8, "clrerr");

        // Back-to-back divide-by-zero: one done per cycle.
        @(negedge clk); a8 = 8'd77; m8 = 8'd0; start8 = 1'b1;
        @(posedge clk); #1;
        chk("b2b.done0", done8, 1);
        chk("b2b.out0", out8, 77);
        @(negedge clk); a8 = 8'd9;
        @(posedge clk); #1;
        chk("b2b.done1", done8, 1);
        chk("b2b.out1", out8, 9);
        chk("b2b.busy", busy8, 0);
        start8 = 1'b0;
        @(posedge clk); #1;
        chk("b2b.drop", done8, 0);

        // start held high, operands alternating every cycle.
        nd = 0;
        for (int e = 0; e < 27; e++) begin
            @(negedge clk);
            if (e % 2 == 1) begin a8 = 8'd13; m8 = 8'd4; end
            else begin a8 = 8'd200; m8 = 8'd7; end
            start8 = 1'b1;
            @(posedge clk); #1;
            if (done8 && nd < 3) begin
                dt[nd] = e; dout[nd] = out8; dquo[nd] = quo8;
                nd++;
            end
        end
        start8 = 1'b0;
        chk("held.count", nd, 3);
        chk("held.t0", dt[0], 8);
        chk("held.t1", dt[1], 17);
        chk("held.t2", dt[2], 26);
        chk("held.out0", dout[0], 4);
        chk("held.quo0", dquo[0], 28);
        chk("held.out1", dout[1], 1);
        chk("held.quo1", dquo[1], 3);
        chk("held.out2", dout[2], 4);
        chk("held.quo2", dquo[2], 28);

        // Reset in the middle of a calculation.
        @(negedge clk); a8 = 8'd200; m8 = 8'd7; start8 = 1'b1;
        @(posedge clk); #1; start8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk("mid.busy", busy8, 0);
        chk("mid.done", done8, 0);
        chk("mid.out", out8, 0);
        chk("mid.quo", quo8, 0);
        chk("mid.err", err8, 0);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8) seen++;
        end
        chk("mid.nodone", seen, 0);
        op8(8'd13, 8'd4, 8'd1, 8'd3, 1'b0, 8, "postrst");

        for (int a = 0; a < 16; a++)
            for (int m = 0; m < 16; m++)
                op4(4'(a), 4'(m));

        op16(16'hFFFF, 16'd1);
        op16(16'd12345, 16'd0);
        op16(16'd1000, 16'd1001);
        for (int i = 0; i < 200; i++)
            op16(16'($urandom), (i % 25 == 0) ? 16'd0 : 16'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
